// File: rtl/dct2_32_row_sched.sv
// Row scheduler for the combinational 32-point DCT-II datapath: registers accepted rows onto
// the datapath inputs, then captures the even/odd results tagged with row index and last-row flag.
module dct2_32_row_sched #(
    parameter int W_IN     = 16,
    parameter int W_E      = 17,
    parameter int W_O      = 27,
    parameter int MAX_ROWS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  cfg_rows,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sof,
    input  logic [32*W_IN-1:0]          in_x,
    output logic [32*W_IN-1:0]          dp_x,
    input  logic [16*W_E-1:0]           dp_ye,
    input  logic [16*W_O-1:0]           dp_yo,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [16*W_E-1:0]           out_ye,
    output logic [16*W_O-1:0]           out_yo,
    output logic [$clog2(MAX_ROWS)-1:0] out_row,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err
);

    localparam int RW = $clog2(MAX_ROWS);
    localparam int CW = RW + 1;  // wide enough to hold MAX_ROWS itself

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic [CW-1:0]   rows_q, rows_d, rows_dec;
    logic            s1_valid, s1_last, s1_load;
    logic [RW-1:0]   s1_row, tag_row;
    logic            tag_last, err_d;
    logic            s2_free, s1_adv, accept;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ACTIVE) || s1_valid || out_valid;

    // Unsupported block sizes fall back to the largest block.
    always_comb begin
        case (cfg_rows)
            6'd4, 6'd8, 6'd16, 6'd32: rows_dec = CW'(cfg_rows);
            default:                  rows_dec = CW'(MAX_ROWS);
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        rows_d    = rows_q;
        s1_load   = 1'b0;
        tag_row   = '0;
        tag_last  = 1'b0;
        err_d     = 1'b0;
        if (accept) begin
            if (in_sof) begin
                // A SOF inside a block is flagged but still restarts the block cleanly.
                err_d     = (state_q == ACTIVE);
                rows_d    = rows_dec;
                row_cnt_d = RW'(1);
                state_d   = ACTIVE;
                s1_load   = 1'b1;
            end else if (state_q == ACTIVE) begin
                s1_load  = 1'b1;
                tag_row  = row_cnt_q;
                tag_last = ({1'b0, row_cnt_q} == rows_q - CW'(1));
                if (tag_last) begin
                    row_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            rows_q    <= CW'(MAX_ROWS);
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            rows_q    <= rows_d;
            err       <= err_d;
        end
    end

    // Stage 1: dp_x only moves on a loaded row, keeping the datapath output stable otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_last  <= 1'b0;
            dp_x     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_row   <= tag_row;
            s1_last  <= tag_last;
            dp_x     <= in_x;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: results held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ye    <= '0;
            out_yo    <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_ye    <= dp_ye;
            out_yo    <= dp_yo;
            out_row   <= s1_row;
            out_last  <= s1_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dct2_32_row_sched.sv
// Bench for dct2_32_row_sched: a behavioural DCT datapath feeds the DUT, a block-level model
// predicts tagged results into a scoreboard, and a monitor checks every delivered result.
module tb_dct2_32_row_sched;

    localparam int W_IN = 16;
    localparam int W_E  = 17;
    localparam int W_O  = 27;
    localparam int XW   = 32 * W_IN;
    localparam int EW   = 16 * W_E;
    localparam int OW   = 16 * W_O;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    cfg_rows = 6'd4;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [XW-1:0] in_x = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, out_last, busy, err;
    logic [XW-1:0] dp_x;
    logic [EW-1:0] dp_ye, out_ye;
    logic [OW-1:0] dp_yo, out_yo;
    logic [4:0]    out_row;

    typedef struct {
        logic [EW-1:0] ye;
        logic [OW-1:0] yo;
        logic [4:0]    row;
        logic          last;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    bit   hold_v = 1'b0;
    bit   rand_ready = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   m_active = 1'b0;
    int   m_idx = 0;
    int   m_rows = 32;

    always #5 clk = ~clk;

    dct2_32_row_sched #(.W_IN(W_IN), .W_E(W_E), .W_O(W_O), .MAX_ROWS(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_rows(cfg_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_x(in_x),
        .dp_x(dp_x), .dp_ye(dp_ye), .dp_yo(dp_yo),
        .out_valid(out_valid), .out_ready(out_ready), .out_ye(out_ye), .out_yo(out_yo),
        .out_row(out_row), .out_last(out_last), .busy(busy), .err(err)
    );

    // Odd-row DCT-II coefficient: 64*sqrt(2)*cos(u*(2k+1)*pi/64), integer HEVC values.
    function automatic int coef(int u, int k);
        int q, s, v;
        q = (u * (2 * k + 1)) % 128;
        s = 1;
        if (q > 64) q = 128 - q;
        if (q > 32) begin q = 64 - q; s = -1; end
        case (q)
            1: v = 90;  3: v = 90;  5: v = 88;  7: v = 85;
            9: v = 82;  11: v = 78; 13: v = 73; 15: v = 67;
            17: v = 61; 19: v = 54; 21: v = 46; 23: v = 38;
            25: v = 31; 27: v = 22; 29: v = 13; 31: v = 4;
            default: v = 0;
        endcase
        return s * v;
    endfunction

    function automatic int samp(logic [XW-1:0] x, int i);
        logic signed [W_IN-1:0] t;
        t = x[i*W_IN +: W_IN];
        return int'(t);
    endfunction

    function automatic logic [EW-1:0] even_fn(logic [XW-1:0] x);
        logic [EW-1:0] r;
        int e;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            e = samp(x, k) + samp(x, 31 - k);
            r[k*W_E +: W_E] = e[W_E-1:0];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] odd_fn(logic [XW-1:0] x);
        logic [OW-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            s = 0;
            for (int k = 0; k < 16; k++)
                s += coef(2 * j + 1, k) * (samp(x, k) - samp(x, 31 - k));
            r[j*W_O +: W_O] = s[W_O-1:0];
        end
        return r;
    endfunction

    always_comb begin
        dp_ye = even_fn(dp_x);
        dp_yo = odd_fn(dp_x);
    end

    function automatic int dec(int c);
        return (c == 4 || c == 8 || c == 16 || c == 32) ? c : 32;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Block-level model of one accepted row; e reports whether it is a protocol error.
    task automatic model_accept(input logic [XW-1:0] x, input bit sof, input logic [5:0] cfg,
                                output bit e);
        e = 1'b0;
        if (sof) begin
            e = m_active;
            m_rows = dec(int'(cfg));
            m_idx = 0;
            m_active = 1'b1;
        end
        if (m_active) begin
            sb.push_back('{even_fn(x), odd_fn(x), 5'(m_idx), (m_idx == m_rows - 1)});
            m_idx++;
            if (m_idx == m_rows) m_active = 1'b0;
        end else begin
            e = 1'b1;
        end
    endtask

    task automatic drive_cycle(input logic [XW-1:0] x, input bit sof, input logic [5:0] cfg,
                               output bit acc);
        bit e;
        in_valid = 1'b1; in_x = x; in_sof = sof; cfg_rows = cfg;
        #3;
        acc = in_ready;
        e = 1'b0;
        if (acc) model_accept(x, sof, cfg, e);
        @(negedge clk);
        check("err", err, acc && e);
    endtask

    task automatic send_row(input logic [XW-1:0] x, input bit sof, input logic [5:0] cfg,
                            output int stalls);
        bit acc;
        stalls = 0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(x, sof, cfg, acc);
            if (acc) break;
            stalls++;
        end
        if (stalls == 50) check("accept_timeout", in_ready, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_sof = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [XW-1:0] rand_row();
        logic [XW-1:0] x;
        for (int i = 0; i < 32; i++)
            x[i*W_IN +: W_IN] = W_IN'($urandom_range(4095)) - W_IN'(2048);
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        m_active = 1'b0; m_idx = 0; hold_v = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_dp_x", dp_x, '0);
        check("rst_out_ye", out_ye, '0);
        check("rst_out_row", {out_row, out_last}, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (hold_v) begin
                    check("hold_ye", out_ye, held.ye);
                    check("hold_yo_tags", {out_yo, out_row, out_last}, {held.yo, held.row, held.last});
                end
                hold_v = 1'b0;
                if (out_valid && !out_ready) begin
                    hold_v = 1'b1;
                    held = '{out_ye, out_yo, out_row, out_last};
                end else if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", out_valid, 1'b0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("out_ye", out_ye, e.ye);
                        check("out_yo", out_yo, e.yo);
                        check("out_row", out_row, e.row);
                        check("out_last", out_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(1));
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XW-1:0] x;
        logic [EW-1:0] ye200;
        int st, tot, k;
        bit acc;
        int cfgs[8] = '{4, 8, 16, 32, 5, 0, 63, 12};

        // Reset, then an all-100 SOF row: Ye = 200 everywhere, Yo = 0, two edges of latency.
        do_reset();
        for (int i = 0; i < 32; i++) x[i*W_IN +: W_IN] = W_IN'(100);
        for (int i = 0; i < 16; i++) ye200[i*W_E +: W_E] = W_E'(200);
        send_row(x, 1'b1, 6'd4, st);
        in_valid = 1'b0;
        check("latency_early", out_valid, 1'b0);
        @(negedge clk);
        check("latency_valid", out_valid, 1'b1);
        check("dc_ye", out_ye, ye200);
        check("dc_yo", out_yo, '0);
        check("dc_tags", {out_row, out_last}, 6'd0);
        idle(3);

        // Impulse row: first odd coefficient column.
        do_reset();
        x = '0;
        x[W_IN-1:0] = W_IN'(1);
        send_row(x, 1'b1, 6'd4, st);
        in_valid = 1'b0;
        @(negedge clk);
        check("imp_yo0", out_yo[0*W_O +: W_O], 27'd90);
        check("imp_yo1", out_yo[1*W_O +: W_O], 27'd90);
        check("imp_yo2", out_yo[2*W_O +: W_O], 27'd88);
        check("imp_yo15", out_yo[15*W_O +: W_O], 27'd4);
        check("imp_ye0", out_ye[W_E-1:0], 17'd1);
        check("imp_ye_rest", out_ye[EW-1:W_E], '0);
        idle(3);

        // Four back-to-back rows, no stalls, busy falls two cycles after the last accept.
        do_reset();
        tot = 0;
        for (int r = 0; r < 4; r++) begin
            send_row(rand_row(), r == 0, 6'd4, st);
            tot += st;
        end
        in_valid = 1'b0;
        check("b2b_stalls", tot, 0);
        check("busy_n1", busy, 1'b1);
        @(negedge clk);
        check("busy_n2", busy, 1'b1);
        @(negedge clk);
        check("busy_n3", busy, 1'b0);
        idle(2);

        // Consumer stall: exactly two rows get in, then in_ready drops.
        do_reset();
        send_row(rand_row(), 1'b1, 6'd8, st);
        idle(3);
        out_ready = 1'b0;
        k = 0;
        x = rand_row();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(x, 1'b0, 6'd8, acc);
            if (acc) begin k++; x = rand_row(); end
        end
        check("stall_accepts", k, 2);
        check("stall_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int r = k + 1; r < 8; r++) begin
            send_row(x, 1'b0, 6'd8, st);
            x = rand_row();
        end
        idle(4);
        check("stall_drained", sb.size(), 0);

        // SOF mid-block restarts tagging; a non-SOF row in IDLE is dropped with err.
        do_reset();
        send_row(rand_row(), 1'b1, 6'd4, st);
        send_row(rand_row(), 1'b0, 6'd4, st);
        send_row(rand_row(), 1'b1, 6'd8, st);
        check("restart_err", err, 1'b1);
        idle(1);
        check("err_one_cycle", err, 1'b0);
        for (int r = 1; r < 8; r++) send_row(rand_row(), 1'b0, 6'd8, st);
        send_row(rand_row(), 1'b0, 6'd8, st);
        check("idle_nonsof_err", err, 1'b1);
        idle(4);
        check("idle_drop", sb.size(), 0);

        // Randomized blocks with a bursty consumer and occasional protocol errors.
        do_reset();
        rand_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int n;
            logic [5:0] c;
            c = 6'(cfgs[$urandom_range(7)]);
            n = dec(int'(c));
            for (int r = 0; r < n; r++) begin
                send_row(rand_row(), (r == 0) || ($urandom_range(19) == 0), c, st);
                idle($urandom_range(2));
            end
            if ($urandom_range(3) == 0) send_row(rand_row(), 1'b0, c, st);
        end
        idle(1);
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("rand_drained", sb.size(), 0);

        // Reset mid-block with a result pending: everything flushes at once.
        do_reset();
        out_ready = 1'b0;
        send_row(rand_row(), 1'b1, 6'd8, st);
        send_row(rand_row(), 1'b0, 6'd8, st);
        idle(1);
        check("pre_reset_valid", out_valid, 1'b1);
        do_reset();
        out_ready = 1'b1;
        send_row(rand_row(), 1'b0, 6'd8, st);
        check("post_reset_err", err, 1'b1);
        idle(4);
        check("post_reset_no_out", sb.size(), 0);
        check("post_reset_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
